// File: rtl/addsub_vector_checker.sv
// ============================================================================
// Module   : addsub_vector_checker
// Brief    : Exhaustive A/B/mode sweep for a ripple-carry adder/subtractor,
//            with a registered error count and first-failure capture.
//            Optional macro ADDSUB_CHK_STOP_ON_FAIL_EN halts on the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_vector_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 c_out,
  input  logic [WIDTH-1:0]     s_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic                 fail_c,
  output logic                 fail_valid
);

  localparam int VW = 2*WIDTH + 1;
  localparam int EW = 2*WIDTH + 2;
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [VW-1:0]     r_v;
  logic [CW-1:0]     r_cnt;
  logic [EW-1:0]     r_err;
  logic [WIDTH-1:0]  r_fail_a;
  logic [WIDTH-1:0]  r_fail_b;
  logic              r_fail_c;
  logic              r_fail_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic              w_c;
  logic [WIDTH-1:0]  w_expected;
  logic              w_mismatch;
  logic              w_last;

  assign w_a        = r_v[WIDTH-1:0];
  assign w_b        = r_v[2*WIDTH-1:WIDTH];
  assign w_c        = r_v[2*WIDTH];
  // Truncation to WIDTH bits gives the modulo-2^WIDTH result for both modes.
  assign w_expected = w_c ? (w_a - w_b) : (w_a + w_b);
  assign w_mismatch = (s_in != w_expected);
  assign w_last     = &r_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_v          <= '0;
      r_cnt        <= '0;
      r_err        <= '0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
      r_fail_c     <= 1'b0;
      r_fail_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_WAIT;
            r_v          <= '0;
            r_cnt        <= CW'(SETTLE);
            r_err        <= '0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_c     <= 1'b0;
            r_fail_valid <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
          end
        end

        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_mismatch) begin
            r_err <= r_err + EW'(1);
            if (!r_fail_valid) begin
              r_fail_a     <= w_a;
              r_fail_b     <= w_b;
              r_fail_c     <= w_c;
              r_fail_valid <= 1'b1;
            end
          end
`ifdef ADDSUB_CHK_STOP_ON_FAIL_EN
          // r_v is left untouched so the failing vector stays on the outputs.
          if (w_mismatch || w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= !w_mismatch && (r_err == '0);
          end else begin
            r_state <= S_WAIT;
            r_v     <= r_v + VW'(1);
            r_cnt   <= CW'(SETTLE);
          end
`else
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= !w_mismatch && (r_err == '0);
          end else begin
            r_state <= S_WAIT;
            r_v     <= r_v + VW'(1);
            r_cnt   <= CW'(SETTLE);
          end
`endif
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_out      = w_a;
  assign b_out      = w_b;
  assign c_out      = w_c;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_a     = r_fail_a;
  assign fail_b     = r_fail_b;
  assign fail_c     = r_fail_c;
  assign fail_valid = r_fail_valid;

endmodule

`default_nettype wire

// File: tb/tb_addsub_vector_checker.sv
// ============================================================================
// Module   : tb_addsub_vector_checker
// Brief    : Self-checking bench for addsub_vector_checker with a behavioural,
//            fault-injectable adder/subtractor and an arithmetic reference sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_vector_checker;

  localparam int W      = 4;
  localparam int ST     = 1;
  localparam int NVEC   = 512;
  localparam int FULL   = NVEC * (ST + 1);
  localparam int BUDGET = FULL + 100;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a_out, b_out, s_in, fail_a, fail_b;
  logic           c_out, busy, done, pass, fail_c, fail_valid;
  logic [2*W+1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  // 0 = correct, 1 = S[0] stuck at 0, 2 = bit 2 flipped on vectors in flip[]
  int fault_mode = 0;
  bit flip [NVEC];

  always #5 clk = ~clk;

  addsub_vector_checker #(.WIDTH(W), .SETTLE(ST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .s_in(s_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_a(fail_a), .fail_b(fail_b), .fail_c(fail_c), .fail_valid(fail_valid)
  );

  // Behavioural device under check.
  int m_val;
  always_comb begin
    m_val = c_out ? (int'(a_out) - int'(b_out)) : (int'(a_out) + int'(b_out));
    m_val = m_val & 15;
    if (fault_mode == 1) m_val = m_val & 14;
    if (fault_mode == 2 && flip[{c_out, b_out, a_out}]) m_val = m_val ^ 4;
    s_in = W'(m_val);
  end

  function automatic int true_sum(input int v);
    int a, b, c;
    a = v % 16; b = (v / 16) % 16; c = v / 256;
    return (c == 1) ? ((a - b + 16) % 16) : ((a + b) % 16);
  endfunction

  function automatic int faulty_sum(input int v, input int mode);
    int s;
    s = true_sum(v);
    if (mode == 1) s = (s / 2) * 2;
    if (mode == 2 && flip[v]) s = (s >= 4 && (s / 4) % 2 == 1) ? s - 4 : s + 4;
    return s;
  endfunction

  // Expected sweep outcome for a given fault mode.
  task automatic ref_sweep(input int mode, output int exp_err, output int exp_cyc,
                           output int first);
    int errs;
    errs = 0; first = -1;
    for (int v = 0; v < NVEC; v++) begin
      if (faulty_sum(v, mode) != true_sum(v)) begin
        if (first < 0) first = v;
        errs++;
      end
    end
`ifdef ADDSUB_CHK_STOP_ON_FAIL_EN
    exp_err = (errs > 0) ? 1 : 0;
    exp_cyc = (errs > 0) ? (first + 1) * (ST + 1) : FULL;
`else
    exp_err = errs;
    exp_cyc = FULL;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulses start, then counts edges until done rises; ign1/ign2 add stray starts.
  task automatic run_sweep(input int ign1, input int ign2, output int cycles,
                           output int busy_low);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cycles = 0; busy_low = 0;
    while (cycles < BUDGET) begin
      if (!busy && !done) busy_low++;
      @(posedge clk); cycles++; #1;
      if (done) break;
      start = (cycles == ign1 || cycles == ign2);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_out, b_out, c_out, busy, done, pass, fail_valid} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got a=%0d b=%0d c=%0d busy=%0d done=%0d pass=%0d fv=%0d, want all 0",
                         a_out, b_out, c_out, busy, done, pass, fail_valid);
    end
    n_checks++;
    if ({err_count, fail_a, fail_b, fail_c} !== '0) begin
      n_fail++; $display("FAIL reset_stats: got err=%0d fa=%0d fb=%0d fc=%0d, want 0",
                         err_count, fail_a, fail_b, fail_c);
    end
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: got %0d want 0", busy);
    end
  endtask

  task automatic test_clean_sweep();
    int cyc, bl, ee, ec, fi;
    fault_mode = 0;
    ref_sweep(0, ee, ec, fi);
    run_sweep(-1, -1, cyc, bl);
    n_checks++;
    if (cyc !== ec) begin n_fail++; $display("FAIL clean_cycles: got %0d want %0d", cyc, ec); end
    n_checks++;
    if (bl !== 0) begin n_fail++; $display("FAIL clean_busy_gap: got %0d low cycles want 0", bl); end
    n_checks++;
    if ({done, pass, busy, fail_valid} !== 4'b1100) begin
      n_fail++; $display("FAIL clean_flags: got done=%0d pass=%0d busy=%0d fv=%0d want 1 1 0 0",
                         done, pass, busy, fail_valid);
    end
    n_checks++;
    if (int'(err_count) !== ee) begin n_fail++; $display("FAIL clean_err: got %0d want %0d", err_count, ee); end
    n_checks++;
    if ({a_out, b_out, c_out} !== {4'd15, 4'd15, 1'b1}) begin
      n_fail++; $display("FAIL clean_last_vec: got a=%0d b=%0d c=%0d want 15 15 1", a_out, b_out, c_out);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      n_fail++; $display("FAIL clean_done_hold: got done=%0d pass=%0d want 1 1", done, pass);
    end
  endtask

  task automatic test_stuck_bit0();
    int cyc, bl, ee, ec, fi;
    do_reset();
    fault_mode = 1;
    ref_sweep(1, ee, ec, fi);
    run_sweep(-1, -1, cyc, bl);
    n_checks++;
    if (cyc !== ec) begin n_fail++; $display("FAIL stuck_cycles: got %0d want %0d", cyc, ec); end
    n_checks++;
    if (int'(err_count) !== ee || pass !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL stuck_result: got err=%0d pass=%0d done=%0d want err=%0d pass=0 done=1",
                         err_count, pass, done, ee);
    end
    n_checks++;
    if ({fail_valid, fail_a, fail_b, fail_c} !== {1'b1, 4'd1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL stuck_first: got fv=%0d a=%0d b=%0d c=%0d want 1 1 0 0",
                         fail_valid, fail_a, fail_b, fail_c);
    end
`ifdef ADDSUB_CHK_STOP_ON_FAIL_EN
    n_checks++;
    if ({a_out, b_out, c_out} !== {4'd1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL stuck_hold_vec: got a=%0d b=%0d c=%0d want 1 0 0", a_out, b_out, c_out);
    end
`endif
    fault_mode = 0;
  endtask

  task automatic test_random_faults();
    int cyc, bl, ee, ec, fi, fa, fb, fc;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int v = 0; v < NVEC; v++) flip[v] = ($urandom_range(0, 40) == 0);
      if (it == 2) flip[$urandom_range(0, NVEC - 1)] = 1'b1;
      fault_mode = 2;
      ref_sweep(2, ee, ec, fi);
      run_sweep(-1, -1, cyc, bl);
      n_checks++;
      if (cyc !== ec) begin n_fail++; $display("FAIL rand%0d_cycles: got %0d want %0d", it, cyc, ec); end
      n_checks++;
      if (int'(err_count) !== ee || pass !== (ee == 0)) begin
        n_fail++; $display("FAIL rand%0d_err: got err=%0d pass=%0d want err=%0d pass=%0d",
                           it, err_count, pass, ee, (ee == 0));
      end
      fa = (fi < 0) ? 0 : fi % 16;
      fb = (fi < 0) ? 0 : (fi / 16) % 16;
      fc = (fi < 0) ? 0 : fi / 256;
      n_checks++;
      if (fail_valid !== (fi >= 0) || int'(fail_a) !== fa || int'(fail_b) !== fb || int'(fail_c) !== fc) begin
        n_fail++; $display("FAIL rand%0d_first: got fv=%0d a=%0d b=%0d c=%0d want fv=%0d a=%0d b=%0d c=%0d",
                           it, fail_valid, fail_a, fail_b, fail_c, (fi >= 0), fa, fb, fc);
      end
    end
    fault_mode = 0;
  endtask

  task automatic test_ignored_start();
    int cyc, bl;
    do_reset();
    fault_mode = 0;
    run_sweep(10, 500 + $urandom_range(0, 20), cyc, bl);
    n_checks++;
    if (cyc !== FULL) begin n_fail++; $display("FAIL ignstart_cycles: got %0d want %0d", cyc, FULL); end
    n_checks++;
    if (err_count !== '0 || pass !== 1'b1 || bl !== 0) begin
      n_fail++; $display("FAIL ignstart_result: got err=%0d pass=%0d busy_low=%0d want 0 1 0",
                         err_count, pass, bl);
    end
  endtask

  task automatic test_midsweep_reset();
    int cyc, bl;
    do_reset();
    fault_mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (200) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_out, b_out, c_out, busy, done, pass, err_count, fail_a, fail_b, fail_c, fail_valid} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got a=%0d b=%0d c=%0d busy=%0d err=%0d fv=%0d want all 0",
                         a_out, b_out, c_out, busy, err_count, fail_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; fault_mode = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midreset_idle: got busy=%0d done=%0d want 0 0", busy, done);
    end
    run_sweep(-1, -1, cyc, bl);
    n_checks++;
    if (cyc !== FULL || pass !== 1'b1 || err_count !== '0) begin
      n_fail++; $display("FAIL midreset_resweep: got cycles=%0d pass=%0d err=%0d want %0d 1 0",
                         cyc, pass, err_count, FULL);
    end
  endtask

  task automatic test_restart_from_done();
    int cyc, bl;
    do_reset();
    fault_mode = 1;
    run_sweep(-1, -1, cyc, bl);
    fault_mode = 0;
    n_checks++;
    if (done !== 1'b1 || err_count === '0) begin
      n_fail++; $display("FAIL restart_pre: got done=%0d err=%0d want done=1 err nonzero", done, err_count);
    end
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_checks++;
    if ({done, pass, busy, fail_valid} !== 4'b0010 || err_count !== '0) begin
      n_fail++; $display("FAIL restart_flags: got done=%0d pass=%0d busy=%0d fv=%0d err=%0d want 0 0 1 0 0",
                         done, pass, busy, fail_valid, err_count);
    end
    n_checks++;
    if ({a_out, b_out, c_out} !== '0) begin
      n_fail++; $display("FAIL restart_vec0: got a=%0d b=%0d c=%0d want 0 0 0", a_out, b_out, c_out);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({a_out, b_out, c_out} !== {4'd1, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL restart_vec1: got a=%0d b=%0d c=%0d want 1 0 0", a_out, b_out, c_out);
    end
  endtask

  initial begin
    for (int v = 0; v < NVEC; v++) flip[v] = 1'b0;
    test_reset();
    test_clean_sweep();
    test_stuck_bit0();
    test_random_faults();
    test_ignored_start();
    test_midsweep_reset();
    test_restart_from_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
